pace_scheduler: RTL and testbench
=================================

Name: pace_scheduler

Overview:
- Demand-mode (VVI-style) pacing controller that sequences the pacing pulse datapath.
- Detects intrinsic heartbeats on a sensed input and enforces a programmable lower-rate interval (LRI), a fixed-width pace pulse and a refractory window.
- Exports pace/sense event strobes and a saturating pace counter for the top-level pin mux.

Parameters:
- CNT_W, 32: width of the interval timer.
- PULSE_CYC, 12_000: pace_out high time, in cycles.
- REFRACT_CYC, 6_000_000: refractory length, in cycles; sensing is ignored during it.
- LRI_MIN, 16_000_000: LRI for cfg_rate=0, in cycles.
- LRI_STEP, 2_000_000: LRI increment per cfg_rate code.
- CFG_DEFAULT, 4: reset rate code. With the defaults this gives LRI = 24_000_000.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  pacing enable, level.
- sense_in  in  1  raw heartbeat input, asynchronous.
- cfg_rate  in  3  rate code.
- cfg_load  in  1  one-cycle strobe that loads cfg_rate.
- pace_out  out  1  pace pulse.
- paced_evt  out  1  one-cycle strobe at pace start.
- sensed_evt  out  1  one-cycle strobe on an accepted intrinsic beat.
- state_out  out  2  current state: IDLE=0, ALERT=1, PACE=2, REFRACT=3.
- pace_count  out  8  number of paces, saturating.

Behaviour:
- Reset (async, active-high): state IDLE, timer 0, pace_out/paced_evt/sensed_evt 0, pace_count 0, lri_reg = LRI_MIN + CFG_DEFAULT*LRI_STEP, sync flops 0.
- Sense path:
  - 2-flop synchronizer, then rising-edge detect: rise = sync2 & ~sync2_d.
  - A sense_in level first sampled high at edge k produces rise during the cycle after edge k+1.
  - When accepted, sensed_evt is high in the cycle after edge k+2.
- lri_reg:
  - On cfg_load, lri_reg <= LRI_MIN + cfg_rate*LRI_STEP, computed at CNT_W width.
  - The new value takes effect immediately. If timer already >= new lri-1 while in ALERT, the pace fires at the next edge.
- Elaboration check: LRI_MIN > PULSE_CYC + REFRACT_CYC.
- Timer: increments by 1 every cycle in ALERT, PACE and REFRACT; held at 0 in IDLE.
- IDLE:
  - enable=1 -> ALERT, timer <= 0.
- ALERT:
  - rise -> REFRACT, timer <= 0, sensed_evt <= 1 for one cycle.
  - Otherwise, if timer >= lri_reg-1 -> PACE, timer <= 0, pace_out <= 1, paced_evt <= 1 for one cycle, pace_count += 1 (saturates at 255).
  - If rise and the timeout coincide, sense wins: no pace is issued.
- PACE:
  - pace_out stays high for exactly PULSE_CYC cycles.
  - At the end: -> REFRACT, pace_out <= 0. The timer is not cleared; it keeps counting from pace start.
  - Sense is ignored.
- REFRACT:
  - Lasts REFRACT_CYC cycles (a separate down-counter or timer compare), then -> ALERT.
  - Rises during REFRACT are dropped, not queued. A level still high on exit produces no new rise.
- Rate invariant: successive pace_out rising edges, or a sensed_evt rise followed by a pace_out rise, are exactly lri_reg cycles apart.
- enable=0 in any state: -> IDLE at the next edge, pace_out <= 0 (an in-progress pulse is truncated), timer <= 0.
- Event strobes are registered and never high for more than one cycle.
- rst asserted mid-pulse: pace_out drops asynchronously.

Decomposition:
- Package pace_pkg:
  - state enum (IDLE, ALERT, PACE, REFRACT);
  - default timing constants;
  - rate-code width (3).
- Sub-module sense_sync:
  - 2-flop synchronizer plus edge detector;
  - ports clk, rst, d_in, rise_out.

Test Plan:
Bench parameters: PULSE_CYC=4, REFRACT_CYC=10, LRI_MIN=40, LRI_STEP=8, CFG_DEFAULT=4 (lri=72).
1. rst, then enable=1, sense_in=0 -> first pace_out rise 72 cycles after ALERT entry, high 4 cycles; next rise 72 cycles later; paced_evt pulses twice; pace_count=2.
2. sense_in rises 30 cycles into ALERT -> sensed_evt 3 edges after first sample; no pace; next pace_out rise exactly 72 cycles after the sensed_evt rise.
3. Second sense edge 5 cycles after an accepted sense (in REFRACT) -> no sensed_evt; pace still 72 cycles after the first event.
4. rise coincides with timer=71 -> sensed_evt=1, pace_out stays 0, pace_count unchanged.
5. At timer=50 in ALERT, cfg_load with cfg_rate=0 -> pace_out rises next cycle (lri 40). Then cfg_rate=7 -> subsequent interval 96.
6. rst mid-pulse -> pace_out 0 immediately, state_out=0, pace_count=0. enable=0 mid-pulse -> pace_out 0 after 1 edge. 300 forced paces -> pace_count saturates at 255.

Source files
------------

// File: rtl/pace_pkg.sv
// Shared types and default timing for the demand-mode pace scheduler.
package pace_pkg;

    // Encoding is visible on state_out, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ALERT   = 2'd1,
        ST_PACE    = 2'd2,
        ST_REFRACT = 2'd3
    } state_e;

    localparam int RATE_W            = 3;
    localparam int DEF_CNT_W         = 32;
    localparam int DEF_PULSE_CYC     = 12_000;
    localparam int DEF_REFRACT_CYC   = 6_000_000;
    localparam int DEF_LRI_MIN       = 16_000_000;
    localparam int DEF_LRI_STEP      = 2_000_000;
    localparam int DEF_CFG_DEFAULT   = 4;

endpackage

// File: rtl/sense_sync.sv
// Two-flop synchronizer for the raw heartbeat input plus rising-edge detect.
module sense_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic rise_out
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync2_d;

    // Metastability chain, then one extra stage to detect the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync2_d <= 1'b0;
        end else begin
            r_sync1   <= d_in;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
        end
    end

    assign rise_out = r_sync2 & ~r_sync2_d;

endmodule

// File: rtl/pace_scheduler.sv
// Demand-mode pacing controller: waits one lower-rate interval for an
// intrinsic beat, paces if none arrives, then blanks sensing while refractory.
module pace_scheduler
    import pace_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int PULSE_CYC   = DEF_PULSE_CYC,
    parameter int REFRACT_CYC = DEF_REFRACT_CYC,
    parameter int LRI_MIN     = DEF_LRI_MIN,
    parameter int LRI_STEP    = DEF_LRI_STEP,
    parameter int CFG_DEFAULT = DEF_CFG_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              sense_in,
    input  logic [RATE_W-1:0] cfg_rate,
    input  logic              cfg_load,
    output logic              pace_out,
    output logic              paced_evt,
    output logic              sensed_evt,
    output logic [1:0]        state_out,
    output logic [7:0]        pace_count
);

    // The pulse and refractory window must fit inside the shortest interval,
    // otherwise the timer would already be past the pace point on ALERT entry.
    if (!(LRI_MIN > PULSE_CYC + REFRACT_CYC)) begin : g_bad_timing
        $error("pace_scheduler: LRI_MIN must exceed PULSE_CYC + REFRACT_CYC");
    end

    localparam int REF_W = (REFRACT_CYC > 1) ? $clog2(REFRACT_CYC) : 1;
    localparam logic [CNT_W-1:0] LRI_RST   = CNT_W'(LRI_MIN + CFG_DEFAULT * LRI_STEP);
    localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_CYC - 1);
    localparam logic [REF_W-1:0] REF_LOAD  = REF_W'(REFRACT_CYC - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] r_lri;
    logic [REF_W-1:0] r_ref_cnt;
    logic             r_pace;
    logic             r_paced_evt;
    logic             r_sensed_evt;
    logic [7:0]       r_count;

    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_timer_nxt;
    logic [REF_W-1:0] w_ref_nxt;
    logic             w_pace_nxt;
    logic             w_paced_nxt;
    logic             w_sensed_nxt;
    logic [7:0]       w_count_nxt;
    logic             w_rise;
    logic             w_timeout;

    sense_sync u_sense_sync (
        .clk      (clk),
        .rst      (rst),
        .d_in     (sense_in),
        .rise_out (w_rise)
    );

    // Compared against the live lri so a rate change applies at once.
    assign w_timeout = (r_timer >= (r_lri - CNT_W'(1)));

    // Rate register: reloaded from the rate code on each cfg_load strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lri <= LRI_RST;
        end else if (cfg_load) begin
            r_lri <= CNT_W'(LRI_MIN) + CNT_W'(cfg_rate) * CNT_W'(LRI_STEP);
        end
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_ref_cnt    <= '0;
            r_pace       <= 1'b0;
            r_paced_evt  <= 1'b0;
            r_sensed_evt <= 1'b0;
            r_count      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_ref_cnt    <= w_ref_nxt;
            r_pace       <= w_pace_nxt;
            r_paced_evt  <= w_paced_nxt;
            r_sensed_evt <= w_sensed_nxt;
            r_count      <= w_count_nxt;
        end
    end

    // Next-state and datapath decode. The timer runs through PACE and REFRACT
    // without clearing so pace-to-pace spacing is exactly one lri.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_ref_nxt    = r_ref_cnt;
        w_pace_nxt   = r_pace;
        w_paced_nxt  = 1'b0;
        w_sensed_nxt = 1'b0;
        w_count_nxt  = r_count;

        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
            w_pace_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_ALERT;
                    w_timer_nxt = '0;
                end
                ST_ALERT: begin
                    // A beat on the same cycle as the timeout inhibits the pace.
                    if (w_rise) begin
                        w_state_nxt  = ST_REFRACT;
                        w_timer_nxt  = '0;
                        w_ref_nxt    = REF_LOAD;
                        w_sensed_nxt = 1'b1;
                    end else if (w_timeout) begin
                        w_state_nxt = ST_PACE;
                        w_timer_nxt = '0;
                        w_pace_nxt  = 1'b1;
                        w_paced_nxt = 1'b1;
                        if (r_count != 8'hFF) begin
                            w_count_nxt = r_count + 8'd1;
                        end
                    end else begin
                        w_timer_nxt = r_timer + CNT_W'(1);
                    end
                end
                ST_PACE: begin
                    w_timer_nxt = r_timer + CNT_W'(1);
                    if (r_timer == PULSE_END) begin
                        w_state_nxt = ST_REFRACT;
                        w_pace_nxt  = 1'b0;
                        w_ref_nxt   = REF_LOAD;
                    end
                end
                ST_REFRACT: begin
                    w_timer_nxt = r_timer + CNT_W'(1);
                    if (r_ref_cnt == '0) begin
                        w_state_nxt = ST_ALERT;
                    end else begin
                        w_ref_nxt = r_ref_cnt - REF_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                    w_pace_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign pace_out   = r_pace;
    assign paced_evt  = r_paced_evt;
    assign sensed_evt = r_sensed_evt;
    assign state_out  = r_state;
    assign pace_count = r_count;

endmodule

// File: tb/tb_pace_scheduler.sv
// Directed bench for pace_scheduler with shortened timing (lri = 72 cycles).
module tb_pace_scheduler;

    localparam int CNT_W       = 32;
    localparam int PULSE_CYC   = 4;
    localparam int REFRACT_CYC = 10;
    localparam int LRI_MIN     = 40;
    localparam int LRI_STEP    = 8;
    localparam int CFG_DEFAULT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       sense_in = 1'b0;
    logic [2:0] cfg_rate = 3'd4;
    logic       cfg_load = 1'b0;
    logic       pace_out;
    logic       paced_evt;
    logic       sensed_evt;
    logic [1:0] state_out;
    logic [7:0] pace_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    pace_scheduler #(
        .CNT_W(CNT_W), .PULSE_CYC(PULSE_CYC), .REFRACT_CYC(REFRACT_CYC),
        .LRI_MIN(LRI_MIN), .LRI_STEP(LRI_STEP), .CFG_DEFAULT(CFG_DEFAULT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .sense_in(sense_in),
        .cfg_rate(cfg_rate), .cfg_load(cfg_load), .pace_out(pace_out),
        .paced_evt(paced_evt), .sensed_evt(sensed_evt), .state_out(state_out),
        .pace_count(pace_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drop to IDLE with sense low, then re-enter ALERT (timer 0 on return).
    task automatic restart();
        enable = 1'b0;
        sense_in = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (pace_out !== 1'b0) begin errors++; $display("FAIL rst_pace got %0d exp 0", pace_out); end
        checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state_out); end
        checks++; if (pace_count !== 8'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", pace_count); end
        checks++; if ({paced_evt, sensed_evt} !== 2'b00) begin errors++; $display("FAIL rst_evts got %b exp 00", {paced_evt, sensed_evt}); end
        rst = 1'b0;
        tick();
        checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL idle_hold got %0d exp 0", state_out); end
    endtask

    task automatic test_lri();
        int n;
        int h;
        enable = 1'b1;
        tick();
        checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL alert_entry got %0d exp 1", state_out); end
        n = 0;
        while (!pace_out && n < 300) begin tick(); n++; end
        exp_cnt++;
        checks++; if (n !== 72) begin errors++; $display("FAIL first_pace_delay got %0d exp 72", n); end
        checks++; if (paced_evt !== 1'b1) begin errors++; $display("FAIL paced_evt1 got %0d exp 1", paced_evt); end
        checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL pace_state got %0d exp 2", state_out); end
        tick();
        checks++; if (paced_evt !== 1'b0) begin errors++; $display("FAIL paced_evt_width got %0d exp 0", paced_evt); end
        h = 1;
        while (pace_out && h < 20) begin tick(); h++; end
        checks++; if (h !== 4) begin errors++; $display("FAIL pulse_width got %0d exp 4", h); end
        checks++; if (state_out !== 2'd3) begin errors++; $display("FAIL post_pulse_state got %0d exp 3", state_out); end
        n = h;
        while (!pace_out && n < 300) begin tick(); n++; end
        exp_cnt++;
        checks++; if (n !== 72) begin errors++; $display("FAIL pace_interval got %0d exp 72", n); end
        checks++; if (pace_count !== 8'(exp_cnt)) begin errors++; $display("FAIL count_two got %0d exp %0d", pace_count, exp_cnt); end
    endtask

    task automatic test_sense();
        int n;
        int extra;
        restart();
        repeat (29) tick();
        sense_in = 1'b1;
        tick();
        checks++; if (sensed_evt !== 1'b0) begin errors++; $display("FAIL sense_early1 got %0d exp 0", sensed_evt); end
        tick();
        checks++; if (sensed_evt !== 1'b0) begin errors++; $display("FAIL sense_early2 got %0d exp 0", sensed_evt); end
        tick();
        checks++; if (sensed_evt !== 1'b1) begin errors++; $display("FAIL sense_latency got %0d exp 1", sensed_evt); end
        checks++; if (state_out !== 2'd3) begin errors++; $display("FAIL sense_state got %0d exp 3", state_out); end
        n = 0; extra = 0;
        while (!pace_out && n < 300) begin
            tick(); n++;
            if (sensed_evt) extra++;
        end
        exp_cnt++;
        checks++; if (n !== 72) begin errors++; $display("FAIL sense_to_pace got %0d exp 72", n); end
        checks++; if (extra !== 0) begin errors++; $display("FAIL held_level_rise got %0d exp 0", extra); end
        checks++; if (pace_count !== 8'(exp_cnt)) begin errors++; $display("FAIL sense_count got %0d exp %0d", pace_count, exp_cnt); end
        sense_in = 1'b0;
    endtask

    task automatic test_refract_drop();
        int n;
        int extra;
        restart();
        repeat (9) tick();
        sense_in = 1'b1;
        repeat (3) tick();
        checks++; if (sensed_evt !== 1'b1) begin errors++; $display("FAIL refr_first_sense got %0d exp 1", sensed_evt); end
        n = 0; extra = 0;
        while (!pace_out && n < 300) begin
            if (n == 2) sense_in = 1'b0;
            if (n == 4) sense_in = 1'b1;
            if (n == 8) sense_in = 1'b0;
            tick(); n++;
            if (sensed_evt) extra++;
        end
        exp_cnt++;
        checks++; if (extra !== 0) begin errors++; $display("FAIL refr_dropped got %0d exp 0", extra); end
        checks++; if (n !== 72) begin errors++; $display("FAIL refr_pace_delay got %0d exp 72", n); end
    endtask

    task automatic test_coincide();
        restart();
        repeat (69) tick();
        sense_in = 1'b1;
        repeat (3) tick();
        checks++; if (sensed_evt !== 1'b1) begin errors++; $display("FAIL coin_sensed got %0d exp 1", sensed_evt); end
        checks++; if (pace_out !== 1'b0) begin errors++; $display("FAIL coin_pace got %0d exp 0", pace_out); end
        checks++; if (paced_evt !== 1'b0) begin errors++; $display("FAIL coin_paced_evt got %0d exp 0", paced_evt); end
        checks++; if (pace_count !== 8'(exp_cnt)) begin errors++; $display("FAIL coin_count got %0d exp %0d", pace_count, exp_cnt); end
        sense_in = 1'b0;
    endtask

    task automatic test_cfg();
        int n;
        bit seen_low;
        restart();
        repeat (50) tick();
        cfg_rate = 3'd0;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        checks++; if (pace_out !== 1'b0) begin errors++; $display("FAIL cfg_load_edge got %0d exp 0", pace_out); end
        tick();
        exp_cnt++;
        checks++; if (pace_out !== 1'b1) begin errors++; $display("FAIL cfg_immediate got %0d exp 1", pace_out); end
        checks++; if (pace_count !== 8'(exp_cnt)) begin errors++; $display("FAIL cfg_count got %0d exp %0d", pace_count, exp_cnt); end
        n = 0; seen_low = 1'b0;
        while (!(seen_low && pace_out) && n < 300) begin
            if (n == 0) begin cfg_rate = 3'd7; cfg_load = 1'b1; end
            if (n == 1) cfg_load = 1'b0;
            tick(); n++;
            if (!pace_out) seen_low = 1'b1;
        end
        exp_cnt++;
        checks++; if (n !== 96) begin errors++; $display("FAIL cfg_rate7_interval got %0d exp 96", n); end
        cfg_rate = 3'd4;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic test_abort_and_saturate();
        int n;
        int evts;
        restart();
        n = 0;
        while (!pace_out && n < 300) begin tick(); n++; end
        rst = 1'b1;
        #1;
        checks++; if (pace_out !== 1'b0) begin errors++; $display("FAIL rst_async_pace got %0d exp 0", pace_out); end
        checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL rst_mid_state got %0d exp 0", state_out); end
        checks++; if (pace_count !== 8'd0) begin errors++; $display("FAIL rst_mid_count got %0d exp 0", pace_count); end
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        tick();
        n = 0;
        while (!pace_out && n < 300) begin tick(); n++; end
        exp_cnt++;
        checks++; if (n !== 72) begin errors++; $display("FAIL post_rst_lri got %0d exp 72", n); end
        tick();
        enable = 1'b0;
        checks++; if (pace_out !== 1'b1) begin errors++; $display("FAIL dis_before_edge got %0d exp 1", pace_out); end
        tick();
        checks++; if (pace_out !== 1'b0) begin errors++; $display("FAIL dis_truncate got %0d exp 0", pace_out); end
        checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL dis_state got %0d exp 0", state_out); end
        cfg_rate = 3'd0;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        enable = 1'b1;
        evts = 0; n = 0;
        while (evts < 300 && n < 13_000) begin
            tick(); n++;
            if (paced_evt) begin
                evts++;
                if (evts == 253) begin
                    checks++; if (pace_count !== 8'd254) begin errors++; $display("FAIL sat_pre got %0d exp 254", pace_count); end
                end
            end
        end
        checks++; if (evts !== 300) begin errors++; $display("FAIL sat_events got %0d exp 300", evts); end
        checks++; if (pace_count !== 8'd255) begin errors++; $display("FAIL sat_count got %0d exp 255", pace_count); end
    endtask

    initial begin
        test_reset();
        test_lri();
        test_sense();
        test_refract_drop();
        test_coincide();
        test_cfg();
        test_abort_and_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
